line_buffer_window: RTL and testbench

Streaming line buffer that sits directly upstream of the convolution datapath. It accepts a raster-order pixel stream over a valid/ready handshake and keeps the previous K-1 image rows in on-chip storage. For every accepted pixel it emits one registered K-tall pixel column, plus position tags and a window-valid flag, so the downstream MAC stage can build the K×K window by shifting columns.

---
 rtl/line_buffer_window.sv | 108 ++++++++++
 tb/tb_line_buffer_window.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_window.sv
`default_nettype none
// line_buffer_window -- K-1 row line buffer emitting one registered K-tall pixel column per accepted pixel.
// Optional LBW_SOF_EN adds an s_sof input that forces a beat to position (0,0). Rev 1.0
module line_buffer_window #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int K      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
`ifdef LBW_SOF_EN
  input  logic                       s_sof,
`endif
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [K*DATA_W-1:0]        m_col,
  output logic [$clog2(IMG_W)-1:0]   m_x,
  output logic [$clog2(IMG_H)-1:0]   m_y,
  output logic                       m_win_valid,
  output logic                       m_last
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(K - 1);
  localparam logic [YW-1:0] Y_WIN  = YW'(K - 1);

  logic [XW-1:0]         x_cnt, pos_x, x_next;
  logic [YW-1:0]         y_cnt, pos_y, y_next;
  logic                  accept;
  logic                  win;
  logic                  last;
  logic [K*DATA_W-1:0]   col;

  // lb[0] is the previous row, lb[K-2] the oldest; intentionally not reset.
  logic [DATA_W-1:0]     lb [0:K-2][0:IMG_W-1];

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

`ifdef LBW_SOF_EN
  assign pos_x = s_sof ? '0 : x_cnt;
  assign pos_y = s_sof ? '0 : y_cnt;
`else
  assign pos_x = x_cnt;
  assign pos_y = y_cnt;
`endif

  always_comb begin
    x_next = pos_x + XW'(1);
    y_next = pos_y;
    if (pos_x == X_LAST) begin
      x_next = '0;
      y_next = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
    end
  end

  assign win  = (pos_x >= X_WIN) && (pos_y >= Y_WIN);
  assign last = (pos_x == X_LAST) && (pos_y == Y_LAST);

  // Reads see pre-write contents because the buffer update is non-blocking.
  assign col[DATA_W-1:0] = s_data;
  for (genvar i = 0; i < K - 1; i++) begin : g_col
    assign col[(i+1)*DATA_W +: DATA_W] = lb[i][pos_x];
  end

  // A beat coinciding with reset is dropped, so the buffers see no write.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb[0][pos_x] <= s_data;
      for (int i = 1; i < K - 1; i++) begin
        lb[i][pos_x] <= lb[i-1][pos_x];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      m_valid     <= 1'b0;
      m_col       <= '0;
      m_x         <= '0;
      m_y         <= '0;
      m_win_valid <= 1'b0;
      m_last      <= 1'b0;
    end else if (accept) begin
      x_cnt       <= x_next;
      y_cnt       <= y_next;
      m_valid     <= 1'b1;
      m_col       <= col;
      m_x         <= pos_x;
      m_y         <= pos_y;
      m_win_valid <= win;
      m_last      <= last;
    end else if (m_ready) begin
      m_valid     <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_window.sv
`default_nettype none
// tb_line_buffer_window -- randomized-handshake bench with a per-column pixel history reference model.
module tb_line_buffer_window;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int K  = 3;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
`ifdef LBW_SOF_EN
  logic          s_sof;
`endif
  logic          m_valid;
  logic          m_ready;
  logic [K*DW-1:0] m_col;
  logic [1:0]    m_x;
  logic [1:0]    m_y;
  logic          m_win_valid;
  logic          m_last;

  line_buffer_window #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K)) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
`ifdef LBW_SOF_EN
    .s_sof(s_sof),
`endif
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_col(m_col),
    .m_x(m_x),
    .m_y(m_y),
    .m_win_valid(m_win_valid),
    .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [K*DW-1:0] col;
    logic [1:0]      x;
    logic [1:0]      y;
    logic            wv;
    logic            last;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  hist [0:W-1][$];
  int          mx;
  int          my;
  int          total;
  int          bad;

  // Reference: the pixel j rows above is the j-th most recent pixel seen at this column.
  task automatic model_accept(input logic [7:0] d, input logic sof);
    exp_t e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    e.col = '0;
    e.col[7:0] = d;
    for (int j = 1; j < K; j++) begin
      if (hist[mx].size() >= j) e.col[j*DW +: DW] = hist[mx][j-1];
    end
    e.x    = 2'(mx);
    e.y    = 2'(my);
    e.wv   = (mx >= K - 1) && (my >= K - 1);
    e.last = (mx == W - 1) && (my == H - 1);
    q.push_back(e);
    hist[mx].push_front(d);
    if (hist[mx].size() > 4) void'(hist[mx].pop_back());
    mx = mx + 1;
    if (mx == W) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end
  endtask

  // Drives one cycle from a negedge, scoreboards the handshake and any drained beat, returns at the next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic sof);
    exp_t e;
    logic drn;
    logic acc;
    logic [K*DW-1:0] mask;
    s_valid = v;
    s_data  = d;
    m_ready = rdy;
`ifdef LBW_SOF_EN
    s_sof   = sof;
`endif
    #1;
    drn = (q.size() != 0) && rdy;
    acc = v && ((q.size() == 0) || rdy);
    total++;
    if (m_valid !== (q.size() != 0) || s_ready !== ((q.size() == 0) || rdy)) begin
      bad++;
      $display("FAIL handshake: m_valid=%b s_ready=%b, want m_valid=%b s_ready=%b",
               m_valid, s_ready, q.size() != 0, (q.size() == 0) || rdy);
    end
    if (drn) begin
      e = q.pop_front();
      mask = e.wv ? {K*DW{1'b1}} : {{(K-1)*DW{1'b0}}, {DW{1'b1}}};
      total++;
      if ((m_col & mask) !== (e.col & mask) || m_x !== e.x || m_y !== e.y ||
          m_win_valid !== e.wv || m_last !== e.last) begin
        bad++;
        $display("FAIL out_beat: col=%h x=%0d y=%0d wv=%b last=%b, want col=%h x=%0d y=%0d wv=%b last=%b",
                 m_col & mask, m_x, m_y, m_win_valid, m_last, e.col & mask, e.x, e.y, e.wv, e.last);
      end
    end
    if (acc) model_accept(d, sof);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || m_col !== '0 || m_x !== 2'd0 || m_y !== 2'd0 ||
        m_win_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: valid=%b col=%h x=%0d y=%0d wv=%b last=%b rdy=%b, want all 0 and rdy=1",
               m_valid, m_col, m_x, m_y, m_win_valid, m_last, s_ready);
    end
    rst = 1'b0;
    for (int p = 0; p < 7; p++) step(1'b1, 8'(p), 1'b1, 1'b0);
    // Reset lands while pixel 7 would be presented.
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    mx = 0;
    my = 0;
    total++;
    if (m_valid !== 1'b0 || m_col !== '0 || m_x !== 2'd0 || m_y !== 2'd0 ||
        m_win_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL midframe_reset: valid=%b col=%h x=%0d y=%0d wv=%b last=%b rdy=%b, want all 0 and rdy=1",
               m_valid, m_col, m_x, m_y, m_win_valid, m_last, s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 8'(p), 1'b1, 1'b0);
      if (p == 0) begin
        total++;
        if (m_valid !== 1'b1 || m_x !== 2'd0 || m_y !== 2'd0 || m_win_valid !== 1'b0) begin
          bad++;
          $display("FAIL post_reset_first: valid=%b x=%0d y=%0d wv=%b, want 1 0 0 0",
                   m_valid, m_x, m_y, m_win_valid);
        end
      end
    end
  endtask

  task automatic test_stream();
    logic want_wv;
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 8'(p), 1'b1, 1'b0);
      want_wv = (p == 10) || (p == 11) || (p == 14) || (p == 15);
      total++;
      if (m_valid !== 1'b1 || m_col[7:0] !== 8'(p) || m_win_valid !== want_wv) begin
        bad++;
        $display("FAIL stream_px%0d: valid=%b data=%0d wv=%b, want 1 %0d %b",
                 p, m_valid, m_col[7:0], m_win_valid, p, want_wv);
      end
      if (p == 10) begin
        total++;
        if (m_col !== {8'd2, 8'd6, 8'd10}) begin
          bad++;
          $display("FAIL col_px10: got %h want 02060a", m_col);
        end
      end
      if (p == 15) begin
        total++;
        if (m_col !== {8'd7, 8'd11, 8'd15} || m_last !== 1'b1) begin
          bad++;
          $display("FAIL col_px15: got %h last=%b want 070b0f last=1", m_col, m_last);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 8'(100 + p), 1'b1, 1'b0);
      if (p == 0) begin
        total++;
        if (m_x !== 2'd0 || m_y !== 2'd0 || m_last !== 1'b0) begin
          bad++;
          $display("FAIL frame_restart: x=%0d y=%0d last=%b want 0 0 0", m_x, m_y, m_last);
        end
      end
      if (p == 10) begin
        total++;
        if (m_col !== {8'd102, 8'd106, 8'd110} || m_win_valid !== 1'b1) begin
          bad++;
          $display("FAIL col_px110: got %h wv=%b want 666a6e wv=1", m_col, m_win_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [K*DW-1:0] c;
    logic [1:0] xx;
    logic [1:0] yy;
    for (int p = 0; p < 6; p++) step(1'b1, 8'(p), 1'b1, 1'b0);
    c  = m_col;
    xx = m_x;
    yy = m_y;
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 8'd6, 1'b0, 1'b0);
      total++;
      if (m_col !== c || m_x !== xx || m_y !== yy || m_valid !== 1'b1 || s_ready !== 1'b0 ||
          m_col[7:0] !== 8'd5) begin
        bad++;
        $display("FAIL stall_hold%0d: col=%h x=%0d y=%0d valid=%b rdy=%b, want col=%h x=%0d y=%0d valid=1 rdy=0",
                 s, m_col, m_x, m_y, m_valid, s_ready, c, xx, yy);
      end
    end
    for (int p = 6; p < 16; p++) begin
      step(1'b1, 8'(p), 1'b1, 1'b0);
      total++;
      if (m_col[7:0] !== 8'(p)) begin
        bad++;
        $display("FAIL resume_px%0d: got %0d want %0d", p, m_col[7:0], p);
      end
    end
  endtask

  task automatic test_random_handshake();
    int sent;
    int cyc;
    logic v;
    logic r;
    sent = 0;
    cyc  = 0;
    while (sent < 16 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (v && ((q.size() == 0) || r)) sent++;
      step(v, 8'(sent - ((v && ((q.size() == 0) || r)) ? 1 : 0)), r, 1'b0);
      cyc++;
    end
    total++;
    if (sent != 16) begin
      bad++;
      $display("FAIL random_budget: accepted %0d pixels, want 16", sent);
    end
    step(1'b0, 8'd0, 1'b1, 1'b0);
    total++;
    if (q.size() != 0 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL random_drain: pending=%0d valid=%b, want 0 0", q.size(), m_valid);
    end
  endtask

`ifdef LBW_SOF_EN
  task automatic test_sof();
    for (int p = 0; p < 6; p++) step(1'b1, 8'(p), 1'b1, 1'b0);
    step(1'b1, 8'd6, 1'b1, 1'b1);
    total++;
    if (m_x !== 2'd0 || m_y !== 2'd0 || m_col[7:0] !== 8'd6) begin
      bad++;
      $display("FAIL sof_tag: x=%0d y=%0d data=%0d want 0 0 6", m_x, m_y, m_col[7:0]);
    end
    step(1'b1, 8'd7, 1'b1, 1'b0);
    total++;
    if (m_x !== 2'd1 || m_y !== 2'd0) begin
      bad++;
      $display("FAIL sof_next: x=%0d y=%0d want 1 0", m_x, m_y);
    end
    step(1'b0, 8'd0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    mx      = 0;
    my      = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
`ifdef LBW_SOF_EN
    s_sof   = 1'b0;
`endif
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_random_handshake();
`ifdef LBW_SOF_EN
    test_sof();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
